// File: rtl/edge_capture_bank.sv
// edge_capture_bank: N_CH pin synchronisers, optional DEBOUNCE_EN filter, per-channel edge/level capture, W1C status, masked IRQs.
// Latency: pin change to capture 3 clk cycles (DB_CYCLES+3 with DEBOUNCE_EN); level mode shows ~filt 2 cycles after change.
// Backpressure: none; pins are sampled every cycle and edges seen while enable is low are dropped, not queued.
module edge_capture_bank #(
    parameter int N_CH       = 8,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter int DB_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CH-1:0]   data_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   irq_mask,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   capture,
    output logic [N_CH-1:0]   irq_vec,
    output logic              irq,
    output logic [N_CH-1:0]   data_sync
);
    localparam logic [N_CH-1:0] IDLE_VEC = {N_CH{IDLE_LEVEL}};

    logic [N_CH-1:0] s1, s2, filt, prev, sticky;
    logic [N_CH-1:0] rise, fall, ev, lvl_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= IDLE_VEC;
            s2 <= IDLE_VEC;
        end else begin
            s1 <= data_in;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt [N_CH];

    // cnt holds how many consecutive cycles s2 has disagreed with filt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= IDLE_VEC;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign filt = s2;
`endif

    // prev tracks filt even while disabled so re-enabling never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= IDLE_VEC;
        else        prev <= filt;
    end

    always_comb begin
        rise     = filt & ~prev;
        fall     = ~filt & prev;
        ev       = '0;
        lvl_mode = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode[2*i +: 2])
                2'b00:   ev[i] = rise[i];
                2'b01:   ev[i] = fall[i];
                2'b10:   ev[i] = rise[i] | fall[i];
                default: lvl_mode[i] = 1'b1;
            endcase
        end
    end

    // set wins over a same-cycle clear so no event is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky <= '0;
        else        sticky <= (sticky & ~clr) | (ev & {N_CH{enable}});
    end

    assign capture   = (sticky & ~lvl_mode) | (~filt & lvl_mode);
    assign irq_vec   = capture & irq_mask;
    assign irq       = |irq_vec;
    assign data_sync = filt;

endmodule

// File: tb/tb_edge_capture_bank.sv
// tb_edge_capture_bank: directed scenarios plus randomized traffic against a behavioural model of edge_capture_bank.
// Latency: model advances once per clock; outputs are compared 1 ns after the rising edge.
// Backpressure: none; stimulus is driven freely every cycle.
module tb_edge_capture_bank;
    localparam int N   = 8;
    localparam int DB  = 16;
    localparam logic [N-1:0] IDLE_V = 8'hFF;
`ifdef DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [N-1:0]   data_in;
    logic [2*N-1:0] mode;
    logic [N-1:0]   irq_mask;
    logic [N-1:0]   clr;
    logic [N-1:0]   capture;
    logic [N-1:0]   irq_vec;
    logic           irq;
    logic [N-1:0]   data_sync;

    int checks = 0;
    int errors = 0;

    edge_capture_bank #(.N_CH(N), .IDLE_LEVEL(1'b1), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .mode(mode),
        .irq_mask(irq_mask), .clr(clr), .capture(capture), .irq_vec(irq_vec),
        .irq(irq), .data_sync(data_sync)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin samples travel through a 2-deep delay, then become the filtered level
    logic [N-1:0] pipe [$];
    logic [N-1:0] m_filt, m_prev, m_sticky;
`ifdef DEBOUNCE_EN
    logic [N-1:0] s2hist [$];
`endif

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(IDLE_V);
        pipe.push_back(IDLE_V);
`ifdef DEBOUNCE_EN
        s2hist.delete();
        for (int k = 0; k < DB; k++) s2hist.push_back(IDLE_V);
`endif
        m_filt   = IDLE_V;
        m_prev   = IDLE_V;
        m_sticky = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] ev;
        ev = '0;
        for (int c = 0; c < N; c++) begin
            if (m_filt[c] != m_prev[c]) begin
                case (mode[2*c +: 2])
                    2'b00:   ev[c] = (m_filt[c] == 1'b1);
                    2'b01:   ev[c] = (m_filt[c] == 1'b0);
                    2'b10:   ev[c] = 1'b1;
                    default: ev[c] = 1'b0;
                endcase
            end
        end
        m_sticky = (m_sticky & ~clr) | (enable ? ev : '0);
        m_prev   = m_filt;
`ifdef DEBOUNCE_EN
        s2hist.push_back(pipe.pop_front());
        void'(s2hist.pop_front());
        pipe.push_back(data_in);
        for (int c = 0; c < N; c++) begin
            bit all_differ;
            all_differ = 1'b1;
            foreach (s2hist[k]) if (s2hist[k][c] == m_filt[c]) all_differ = 1'b0;
            if (all_differ) m_filt[c] = ~m_filt[c];
        end
`else
        void'(pipe.pop_front());
        pipe.push_back(data_in);
        m_filt = pipe[0];
`endif
    endtask

    function automatic logic [N-1:0] exp_capture();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++)
            r[c] = (mode[2*c +: 2] == 2'b11) ? ~m_filt[c] : m_sticky[c];
        return r;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable = 1'b1; data_in = 8'hFF; mode = '0; irq_mask = 8'hFF; clr = '0;
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (capture !== 8'h00) begin errors++; $display("FAIL reset_capture got %h want 00", capture); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (irq_vec !== 8'h00) begin errors++; $display("FAIL reset_irq_vec got %h want 00", irq_vec); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (data_sync !== 8'hFF) begin errors++; $display("FAIL reset_data_sync got %h want ff", data_sync); end
    endtask

    task automatic test_rise_ch0();
        mode = '0; irq_mask = 8'h01;
        data_in[0] = 1'b0;
        repeat (LAT + 2) tick();
        checks++; if (capture[0] !== 1'b0) begin errors++; $display("FAIL rise_fall_ignored got %b want 0", capture[0]); end
        data_in[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            checks++; if (capture[0] !== (k == LAT)) begin errors++; $display("FAIL rise_latency k=%0d got %b want %b", k, capture[0], k == LAT); end
            checks++; if (irq !== (k == LAT)) begin errors++; $display("FAIL rise_irq k=%0d got %b want %b", k, irq, k == LAT); end
        end
        clr = 8'h01; tick(); clr = '0;
        checks++; if (capture[0] !== 1'b0) begin errors++; $display("FAIL rise_clr got %b want 0", capture[0]); end
    endtask

    task automatic test_both_ch2();
        mode = '0; mode[5:4] = 2'b10; irq_mask = 8'h04;
        data_in[2] = 1'b0;
        repeat (LAT) tick();
        checks++; if (capture[2] !== 1'b1) begin errors++; $display("FAIL both_first_edge got %b want 1", capture[2]); end
        repeat (7) tick();
        checks++; if (capture[2] !== 1'b1) begin errors++; $display("FAIL both_sticky got %b want 1", capture[2]); end
        data_in[2] = 1'b1;
        repeat (LAT - 1) tick();
        clr = 8'h04; tick(); clr = '0;
        checks++; if (capture[2] !== 1'b1) begin errors++; $display("FAIL both_set_beats_clr got %b want 1", capture[2]); end
        clr = 8'h04; tick(); clr = '0;
        checks++; if (capture[2] !== 1'b0) begin errors++; $display("FAIL both_clr got %b want 0", capture[2]); end
    endtask

    task automatic test_level_ch3();
        mode = '0; mode[7:6] = 2'b11; irq_mask = 8'h00;
        data_in[3] = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            checks++; if (capture[3] !== (k >= LAT - 1)) begin errors++; $display("FAIL level_assert k=%0d got %b want %b", k, capture[3], k >= LAT - 1); end
            checks++; if (irq_vec[3] !== 1'b0) begin errors++; $display("FAIL level_masked got %b want 0", irq_vec[3]); end
        end
        data_in[3] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            checks++; if (capture[3] !== (k < LAT - 1)) begin errors++; $display("FAIL level_release k=%0d got %b want %b", k, capture[3], k < LAT - 1); end
        end
        irq_mask = 8'h08; data_in[3] = 1'b0;
        repeat (LAT) tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_unmasked_irq got %b want 1", irq); end
        data_in[3] = 1'b1;
        repeat (LAT) tick();
    endtask

    task automatic test_enable_ch1();
        mode = '0; mode[3:2] = 2'b01; irq_mask = 8'h02;
        enable = 1'b0; data_in[1] = 1'b0;
        repeat (LAT + 2) tick();
        enable = 1'b1;
        repeat (4) tick();
        checks++; if (capture[1] !== 1'b0) begin errors++; $display("FAIL enable_edge_lost got %b want 0", capture[1]); end
        data_in[1] = 1'b1;
        repeat (LAT + 2) tick();
        checks++; if (capture[1] !== 1'b0) begin errors++; $display("FAIL enable_rise_ignored got %b want 0", capture[1]); end
        data_in[1] = 1'b0;
        repeat (LAT) tick();
        checks++; if (capture[1] !== 1'b1) begin errors++; $display("FAIL enable_next_fall got %b want 1", capture[1]); end
        clr = 8'h02; tick(); clr = '0;
        data_in[1] = 1'b1;
        repeat (LAT + 2) tick();
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_debounce_ch4();
        mode = '0; mode[9:8] = 2'b01; irq_mask = 8'h10;
        data_in[4] = 1'b0; repeat (10) tick();
        data_in[4] = 1'b1; repeat (30) tick();
        checks++; if (capture[4] !== 1'b0) begin errors++; $display("FAIL debounce_glitch got %b want 0", capture[4]); end
        data_in[4] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (capture[4] !== (k >= 19)) begin errors++; $display("FAIL debounce_latency k=%0d got %b want %b", k, capture[4], k >= 19); end
        end
        data_in[4] = 1'b1; repeat (DB + 6) tick();
        clr = 8'h10; tick(); clr = '0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) data_in = data_in ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) mode = 16'($urandom);
            irq_mask = 8'($urandom);
            enable   = ($urandom_range(0, 7) != 0);
            clr      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            tick();
            checks++; if (capture !== exp_capture()) begin errors++; $display("FAIL rand_capture n=%0d got %h want %h", n, capture, exp_capture()); end
            checks++; if (irq_vec !== (exp_capture() & irq_mask)) begin errors++; $display("FAIL rand_irq_vec n=%0d got %h want %h", n, irq_vec, exp_capture() & irq_mask); end
            checks++; if (irq !== |(exp_capture() & irq_mask)) begin errors++; $display("FAIL rand_irq n=%0d got %b want %b", n, irq, |(exp_capture() & irq_mask)); end
            checks++; if (data_sync !== m_filt) begin errors++; $display("FAIL rand_data_sync n=%0d got %h want %h", n, data_sync, m_filt); end
        end
        clr = '0; enable = 1'b1;
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (capture !== 8'h00) begin errors++; $display("FAIL arst_capture got %h want 00", capture); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b want 0", irq); end
        checks++; if (data_sync !== 8'hFF) begin errors++; $display("FAIL arst_data_sync got %h want ff", data_sync); end
        data_in = 8'hFF; irq_mask = 8'hFF; enable = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (capture !== 8'h00) begin errors++; $display("FAIL arst_no_spurious k=%0d got %h want 00", k, capture); end
        end
    endtask

    initial begin
        test_reset();
        test_rise_ch0();
        test_both_ch2();
        test_level_ch3();
        test_enable_ch1();
`ifdef DEBOUNCE_EN
        test_debounce_ch4();
`endif
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_capture_bank.md
Name: edge_capture_bank

Overview:
Parametrised multi-channel successor to the single-bit edge capture block: N_CH independent input channels, each with a 2-FF synchroniser, an optional debounce filter, a per-channel edge mode, a sticky capture bit and a maskable interrupt. It sits between raw GPIO/button/sensor pins and the bus-facing register file. It provides write-1-to-clear capture bits, per-channel IRQs, and one aggregated IRQ line to the processor.

Parameters:
N_CH, 8, number of input channels
IDLE_LEVEL, 1, reset value of the synchroniser and filter stages (pins idle high, active-low)
DB_CYCLES, 16, debounce stability window in clk cycles (≥1; used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global capture enable; when low, capture bits cannot set
data_in  input  N_CH  raw asynchronous channel inputs
mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 level-low
irq_mask  input  N_CH  per-channel interrupt enable
clr  input  N_CH  per-channel write-1-to-clear pulse (one cycle per write)
capture  output  N_CH  per-channel capture status
irq_vec  output  N_CH  per-channel masked interrupt
irq  output  1  OR-reduction of irq_vec
data_sync  output  N_CH  synchronised, filtered input level

Behaviour:
- Reset (async, rst_n=0): sync stages, filter, prev-level and counters = IDLE_LEVEL/0; sticky capture regs = 0; capture = 0 except level-mode channels, which show ~IDLE_LEVEL (0 at default); irq_vec and irq follow the same rule with the mask applied.
- Synchroniser: s1 <= data_in; s2 <= s1. filt = s2 without the debounce filter.
- Edge detect: prev <= filt every cycle, regardless of enable. rise = filt & ~prev; fall = ~filt & prev; both = rise | fall.
- Sticky reg per channel: set on the event selected by its mode (rise/fall/both) when enable=1. It clears on clr[i], independent of enable. A set and a clear in the same cycle leave the bit set (no lost event).
- Mode 11: capture[i] = ~filt[i], combinational. The sticky reg does not update (holds, clr still works). A mode change never clears the sticky reg.
- Latency, no debounce: a pin change set up before edge k produces capture=1 after edge k+2 (3 cycles).
- irq_vec[i] = capture[i] & irq_mask[i]; irq = |irq_vec. Both are combinational from registers, with no added latency.
- Mask low does not block capture; unmasking with a pending capture raises irq immediately.
- enable low: edges are lost (not queued). prev keeps tracking, so raising enable does not create a false edge.
- Async reset mid-operation: all state returns to reset values. The first post-reset cycles produce no spurious edge when the pin is at IDLE_LEVEL.

Optional Feature:
DEBOUNCE_EN. When defined, each channel gets a counter of width clog2(DB_CYCLES+1), reset 0, and a filt register, reset IDLE_LEVEL:
- if s2 == filt, cnt <= 0;
- else if cnt == DB_CYCLES-1, filt <= s2 and cnt <= 0;
- else cnt <= cnt+1.
A change must persist DB_CYCLES consecutive cycles, so edge latency = DB_CYCLES+3 cycles. Shorter glitches never reach the edge detector.
When not defined, filt = s2 directly, no counter exists, and latency is 3 cycles.

Test Plan:
- Reset, N_CH=8, all inputs 1, mode=all 00 → capture=0x00, irq=0; data_sync=0xFF after 2 cycles.
- Ch0 rising edge, mode 00, enable=1, mask=0x01 → capture[0]=1 and irq=1 exactly 3 cycles later. clr=0x01 for 1 cycle → capture[0]=0 next cycle.
- Ch2 mode 10, pulse 1→0→1 with 10-cycle spacing, no clr → capture[2] set on the first edge and stays 1. A clr coinciding with the second edge's set cycle → capture[2] remains 1.
- Ch3 mode 11, data_in[3]=0 → capture[3]=1 after 2 cycles; release to 1 → capture[3]=0 after 2 cycles; mask=0 → irq_vec[3]=0 throughout.
- enable=0 with a falling edge on ch1 (mode 01), then enable=1 → capture[1] stays 0; the next falling edge sets it.
- DEBOUNCE_EN, DB_CYCLES=16: a 10-cycle low glitch on ch4 → no capture. A 20-cycle low on ch4 (mode 01) → capture[4]=1 exactly 19 cycles after the input change.
